// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for DIV/DIVU in EX.
// Holds the pipeline via stall_for_ex until {remainder, quotient} is ready.
module ex_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        stall_for_ex
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor;
    logic        neg_quot;
    logic        neg_rem;

    logic [64:0] shifted;
    logic [33:0] diff;
    logic [64:0] step;
    logic [31:0] quot_abs;
    logic [31:0] rem_abs;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] abs1;
    logic [31:0] abs2;

    // Operand magnitudes; 0x80000000 stays 0x80000000 as an unsigned value.
    always_comb begin
        abs1 = opdata1;
        abs2 = opdata2;
        if (div_signed && opdata1[31]) abs1 = ~opdata1 + 32'd1;
        if (div_signed && opdata2[31]) abs2 = ~opdata2 + 32'd1;
    end

    // One restoring iteration: shift, trial-subtract, keep or restore.
    always_comb begin
        shifted  = work << 1;
        diff     = {1'b0, shifted[64:32]} - {2'b00, divisor};
        if (diff[33]) step = shifted;
        else          step = {diff[32:0], shifted[31:1], 1'b1};
        quot_abs = step[31:0];
        rem_abs  = step[63:32];
        quot_fix = neg_quot ? (~quot_abs + 32'd1) : quot_abs;
        rem_fix  = neg_rem  ? (~rem_abs + 32'd1)  : rem_abs;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next state; annul overrides everything, a dropped start aborts.
    always_comb begin
        next_state = state;
        if (annul) begin
            next_state = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (div_start) begin
                        if (opdata2 == 32'd0) next_state = S_BYZERO;
                        else                  next_state = S_ON;
                    end
                end
                S_BYZERO: begin
                    if (div_start) next_state = S_END;
                    else           next_state = S_IDLE;
                end
                S_ON: begin
                    if (!div_start)         next_state = S_IDLE;
                    else if (cnt == 6'd31)  next_state = S_END;
                end
                S_END:   next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Datapath: latch operands, iterate, and load the final result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 6'd0;
            work     <= 65'd0;
            divisor  <= 32'd0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= 64'd0;
        end else begin
            if (state == S_IDLE && next_state == S_ON) begin
                cnt      <= 6'd0;
                work     <= {33'd0, abs1};
                divisor  <= abs2;
                neg_quot <= div_signed & (opdata1[31] ^ opdata2[31]);
                neg_rem  <= div_signed & opdata1[31];
            end
            if (state == S_ON && next_state != S_IDLE) begin
                work <= step;
                cnt  <= cnt + 6'd1;
            end
            if (state == S_ON && next_state == S_END)
                result <= {rem_fix, quot_fix};
            if (state == S_BYZERO && next_state == S_END)
                result <= 64'd0;
        end
    end

    // Outputs: ready marks END; stall holds EX until the result is there.
    always_comb begin
        ready        = (state == S_END);
        stall_for_ex = div_start & ~ready & ~annul & ~rst;
    end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative 32-bit radix-2 divider in the EX stage of the 5-stage pipeline. It serves DIV and DIVU. It produces the `stall_for_ex` request consumed by the pipeline control block, which freezes PC/IF/ID/EX (`StallBus` pattern 00_1111) while a division is in flight. The result is delivered as {remainder, quotient} for the HI/LO write in the same EX cycle that the stall drops.

## Interface
- No parameters; operand width fixed at 32.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `div_start`  in  1  EX holds a DIV/DIVU; stays high while EX is stalled.
- `div_signed`  in  1  1 = DIV (signed), 0 = DIVU; sampled with `div_start` in IDLE.
- `opdata1`  in  32  dividend (rs); sampled in IDLE.
- `opdata2`  in  32  divisor (rt); sampled in IDLE.
- `annul`  in  1  cancel in-flight division (exception/flush); highest priority after `rst`.
- `result`  out  64  {remainder[63:32], quotient[31:0]}; registered.
- `ready`  out  1  result valid; high only in END.
- `stall_for_ex`  out  1  to pipeline control; combinational.

## Operation
- States: IDLE, BYZERO, ON, END. Iteration counter `cnt` is 6 bits. Working register is 65 bits (partial remainder plus dividend shift).
- IDLE:
  - `div_start`=1 and `opdata2`==0: go to BYZERO.
  - `div_start`=1 and `opdata2`!=0: latch |opdata1|, |opdata2| (absolute value only if `div_signed`; |0x80000000| = 0x80000000 as unsigned), latch sign flags, clear `cnt`, go to ON.
  - Otherwise stay.
- BYZERO: load `result`=0, go to END.
- ON, one iteration per cycle:
  - Shift the working register left by 1.
  - Trial-subtract the divisor from the upper 33 bits.
  - If the difference is non-negative, keep it and set quotient bit = 1; else restore and set quotient bit = 0.
  - `cnt`++. After the iteration where `cnt`==31, apply sign fixup, load `result`, go to END.
- Sign fixup (signed only):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Two's-complement wrap; 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- END: `ready`=1. Go to IDLE unconditionally. `result` holds until the next load.
- `div_start` dropping while in BYZERO or ON: abort to IDLE, no `ready`, `result` unchanged.
- `annul`=1 in any state: next state IDLE, `ready`=0 next cycle, `result` unchanged. `annul` and `div_start` together in IDLE: no start.
- `stall_for_ex` = `div_start` & ~`ready` & ~`annul` & ~`rst`.

## Timing
- Reset values: state IDLE, `cnt`=0, `result`=0, `ready`=0, `stall_for_ex`=0.
- Normal division, with cycle 0 = first cycle `div_start` is seen in IDLE:
  - ON occupies cycles 1–32.
  - END at cycle 33: `ready`=1 and `result` valid.
  - `stall_for_ex` is high in cycles 0–32 and low in cycle 33, so EX advances at the end of cycle 33.
- Divide by zero: BYZERO in cycle 1, END in cycle 2, `result`=0. Stall is high in cycles 0–1.
- Back-to-back divides: a new `div_start` in cycle 34 (IDLE) is accepted. There is no dead cycle beyond END.
- Operands must be stable in IDLE only. Changes on `opdata*` during ON are ignored.
- `rst` mid-operation: IDLE on the next edge, `result` cleared to 0.

## Test plan
- DIVU 100 / 7:
  - `stall_for_ex` is high for exactly 33 cycles.
  - `ready` is high in cycle 33 only.
  - `result` = {0x00000002, 0x0000000E}.
- DIV -7 / 2 (0xFFFFFFF9 / 0x00000002): `result` = {0xFFFFFFFF, 0xFFFFFFFD}.
- DIV 7 / -2: `result` = {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF: `result` = {0x00000000, 0x80000000}.
- DIVU 0xFFFFFFFF / 0x00000001: `result` = {0x00000000, 0xFFFFFFFF}.
- DIVU 5 / 0:
  - `ready` in cycle 2.
  - `result` = 0.
  - Stall is high in cycles 0–1 only.
- `annul` pulsed in cycle 10 of 100/7:
  - `stall_for_ex` is 0 in cycle 10.
  - Unit is IDLE in cycle 11; `ready` never asserts.
  - A fresh start of 9/3 then yields {0, 3} at its own cycle 33.
- Two divides back-to-back: 20/6 in END, then `div_start` held for 13/4 in the next cycle. Results are {2, 3}, then {1, 3}; the second `ready` comes 34 cycles after the first.
- `rst` asserted in cycle 15: IDLE, `result`=0, `stall_for_ex`=0 while `rst` is high.
